// File: rtl/rsa_mmio_pkg.sv
// Shared definitions for the memory-mapped modular-exponentiation block:
// register word offsets, STATUS bit positions and the controller state set.
package rsa_mmio_pkg;

  // Word offsets inside the peripheral's address window (ALUResult[4:2]).
  localparam logic [2:0] OFF_BASE   = 3'd0;
  localparam logic [2:0] OFF_EXP    = 3'd1;
  localparam logic [2:0] OFF_MOD    = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_RESULT = 3'd5;

  // STATUS register bit positions.
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  // Square-and-multiply controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    STEP  = 3'd2,
    MUL   = 3'd3,
    SQR   = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mod_mul.sv
// Interleaved (MSB-first, one multiplier bit per cycle) modular multiplier.
// Computes p = a*b mod m for a,b < m. The first bit is folded in on the
// launch edge, so done pulses exactly W cycles after start is sampled.
module mod_mul #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         done,
  output logic [W-1:0] p
);

  localparam int AW = W + 2;
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // One shift-add step: acc*2 (+b), then two conditional subtractions keep
  // the accumulator below m. The W+2 bit intermediate holds up to 3m-1.
  function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc,
                                           input logic          abit,
                                           input logic [W-1:0]  bb,
                                           input logic [W-1:0]  mm);
    logic [AW-1:0] t;
    logic [AW-1:0] mx;
    mx = {2'b00, mm};
    t  = {1'b0, acc, 1'b0};
    if (abit) t = t + {2'b00, bb};
    if (t >= mx) t = t - mx;
    if (t >= mx) t = t - mx;
    return t[W-1:0];
  endfunction

  // Next-state: capture operands on launch, then consume one bit per cycle.
  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      acc_d = mm_step(acc_q, a_q[W-1], b_q, m_q);
      a_d   = a_q << 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      acc_d  = mm_step('0, a[W-1], b, m);
      a_d    = a << 1;
      b_d    = b;
      m_d    = m;
      cnt_d  = CW'(W - 1);
      busy_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/rsa_modexp_mmio.sv
// Memory-mapped modular exponentiation coprocessor. Firmware loads BASE,
// EXP and MOD, writes CTRL.bit0, polls STATUS and reads RESULT. The loop is
// right-to-left square-and-multiply driven by a shared modular multiplier.
module rsa_modexp_mmio
  import rsa_mmio_pkg::*;
#(
  parameter int W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e state_q, state_d;

  logic [W-1:0] base_q, base_d;
  logic [W-1:0] exp_q, exp_d;
  logic [W-1:0] mod_q, mod_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] e_q, e_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic         busy;
  logic         wr_en;
  logic         start;
  logic         chk_err;
  logic         mul_start;
  logic [W-1:0] mul_a;
  logic         mul_done;
  logic [W-1:0] mul_p;

  // Only the low W data bits are architectural; the rest are dropped.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Bus writes are accepted only while the engine is not running.
  assign wr_en   = sel & we & ~busy;
  assign start   = wr_en & (addr == OFF_CTRL) & wdata[0];
  assign chk_err = (mod_q == '0) | (base_q >= mod_q);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic; a start seen in DONE re-launches directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? CHECK : IDLE;
      CHECK:      state_d = chk_err ? DONE : STEP;
      STEP: begin
        if (e_q == '0)  state_d = DONE;
        else if (e_q[0]) state_d = MUL;
        else             state_d = SQR;
      end
      MUL:        if (mul_done) state_d = SQR;
      SQR:        if (mul_done) state_d = STEP;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag and multiplier launch/operand select. The square
  // is launched on the same cycle the multiply completes.
  always_comb begin
    busy      = 1'b0;
    mul_start = 1'b0;
    mul_a     = b_q;
    case (state_q)
      CHECK: busy = 1'b1;
      STEP: begin
        busy      = 1'b1;
        mul_start = (e_q != '0);
        mul_a     = e_q[0] ? r_q : b_q;
      end
      MUL: begin
        busy      = 1'b1;
        mul_start = mul_done;
      end
      SQR:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath next-state: register-file writes plus loop working registers.
  always_comb begin
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    result_d = result_q;
    r_d      = r_q;
    b_d      = b_q;
    e_d      = e_q;
    done_d   = done_q;
    err_d    = err_q;
    if (wr_en) begin
      case (addr)
        OFF_BASE: base_d = wdata[W-1:0];
        OFF_EXP:  exp_d  = wdata[W-1:0];
        OFF_MOD:  mod_d  = wdata[W-1:0];
        default:  ;
      endcase
    end
    if (start) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    case (state_q)
      CHECK: begin
        if (chk_err) begin
          err_d    = 1'b1;
          result_d = '0;
          done_d   = 1'b1;
        end else begin
          r_d = (mod_q == W'(1)) ? '0 : W'(1);
          b_d = base_q;
          e_d = exp_q;
        end
      end
      STEP: begin
        if (e_q == '0) begin
          result_d = r_q;
          done_d   = 1'b1;
        end
      end
      MUL: if (mul_done) r_d = mul_p;
      SQR: begin
        if (mul_done) begin
          b_d = mul_p;
          e_d = e_q >> 1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any run and discards its result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      result_q <= '0;
      r_q      <= '0;
      b_q      <= '0;
      e_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      r_q      <= r_d;
      b_q      <= b_d;
      e_q      <= e_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  mod_mul #(.W(W)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (mul_a),
    .b     (b_q),
    .m     (mod_q),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Read mux: combinational from addr, zero outside the window.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        OFF_BASE:   rdata = 32'(base_q);
        OFF_EXP:    rdata = 32'(exp_q);
        OFF_MOD:    rdata = 32'(mod_q);
        OFF_STATUS: begin
          rdata[ST_BUSY] = busy;
          rdata[ST_DONE] = done_q;
          rdata[ST_ERR]  = err_q;
        end
        OFF_RESULT: rdata = 32'(result_q);
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = done_q;

endmodule

// File: tb/tb_rsa_modexp_mmio.sv
// Directed bench for the modular-exponentiation peripheral and its multiplier.
module tb_rsa_modexp_mmio;
  import rsa_mmio_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  logic        mm_start;
  logic [15:0] mm_a, mm_b, mm_m, mm_p;
  logic        mm_done;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] rd;
  int          cyc;
  logic        ok;

  always #5 clk = ~clk;

  rsa_modexp_mmio #(.W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  mod_mul #(.W(16)) u_mm (
    .clk   (clk),
    .reset (reset),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .m     (mm_m),
    .done  (mm_done),
    .p     (mm_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
      $display("check %s: observed %0d", tag, obs);
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output logic seen);
    logic [31:0] s;
    cycles = 0;
    seen   = 1'b0;
    while (cycles < budget) begin
      bus_rd(OFF_STATUS, s);
      if (s[ST_DONE]) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic load_and_start(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    bus_wr(OFF_BASE, b);
    bus_wr(OFF_EXP, e);
    bus_wr(OFF_MOD, m);
    bus_wr(OFF_CTRL, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    mm_start = 1'b0; mm_a = '0; mm_b = '0; mm_m = '0;
    repeat (2) @(posedge clk);
    #1;
    bus_rd(OFF_STATUS, rd); check("reset_status", rd, 32'd0);
    bus_rd(OFF_RESULT, rd); check("reset_result", rd, 32'd0);
    bus_rd(OFF_BASE, rd);   check("reset_base", rd, 32'd0);
    check("reset_irq", irq, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 4^13 mod 497 = 445
    bus_wr(OFF_BASE, 32'd4);
    bus_wr(OFF_EXP, 32'd13);
    bus_wr(OFF_MOD, 32'd497);
    bus_rd(OFF_BASE, rd); check("base_rw", rd, 32'd4);
    bus_rd(OFF_CTRL, rd); check("ctrl_reads_zero", rd, 32'd0);
    bus_wr(OFF_CTRL, 32'd1);
    bus_rd(OFF_STATUS, rd); check("busy_after_start", rd, 32'd1);
    wait_done(2000, cyc, ok); check("done_4_13", ok, 1'b1);
    bus_rd(OFF_RESULT, rd); check("result_4_13", rd, 32'd445);
    bus_rd(OFF_STATUS, rd); check("status_4_13", rd, 32'd2);
    check("irq_4_13", irq, 1'b1);

    // 2^10 mod 1000 = 24
    load_and_start(32'd2, 32'd10, 32'd1000);
    wait_done(2000, cyc, ok); check("done_2_10", ok, 1'b1);
    bus_rd(OFF_RESULT, rd); check("result_2_10", rd, 32'd24);

    // Modulus of one -> 0
    load_and_start(32'd0, 32'd3, 32'd1);
    wait_done(2000, cyc, ok); check("done_mod1", ok, 1'b1);
    bus_rd(OFF_RESULT, rd); check("result_mod1", rd, 32'd0);
    bus_rd(OFF_STATUS, rd); check("status_mod1", rd, 32'd2);

    // EXP=0, modulus 13 -> 1
    load_and_start(32'd5, 32'd0, 32'd13);
    wait_done(2000, cyc, ok); check("done_exp0", ok, 1'b1);
    bus_rd(OFF_RESULT, rd); check("result_exp0", rd, 32'd1);

    // Zero modulus -> error within 3 cycles, RESULT cleared
    load_and_start(32'd0, 32'd5, 32'd0);
    wait_done(3, cyc, ok); check("done_mod0_fast", ok, 1'b1);
    bus_rd(OFF_STATUS, rd); check("status_mod0", rd, 32'd6);
    bus_rd(OFF_RESULT, rd); check("result_mod0", rd, 32'd0);

    // BASE >= modulus -> error
    load_and_start(32'd20, 32'd3, 32'd13);
    wait_done(3, cyc, ok); check("done_base_ge_mod", ok, 1'b1);
    bus_rd(OFF_STATUS, rd); check("status_base_ge_mod", rd, 32'd6);

    // Writes during a run are ignored; start clears err
    load_and_start(32'd4, 32'd13, 32'd497);
    bus_rd(OFF_STATUS, rd); check("start_clears_err", rd, 32'd1);
    bus_wr(OFF_BASE, 32'd9);
    bus_wr(OFF_CTRL, 32'd1);
    bus_rd(OFF_RESULT, rd); check("result_held_busy", rd, 32'd0);
    wait_done(2000, cyc, ok); check("done_busy_wr", ok, 1'b1);
    bus_rd(OFF_RESULT, rd); check("result_busy_wr", rd, 32'd445);
    bus_rd(OFF_BASE, rd);   check("base_kept_busy_wr", rd, 32'd4);

    // Reset mid-run aborts, then 3^5 mod 7 = 5
    load_and_start(32'd4, 32'd13, 32'd497);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    bus_rd(OFF_STATUS, rd); check("status_async_reset", rd, 32'd0);
    check("irq_async_reset", irq, 1'b0);
    bus_rd(OFF_RESULT, rd); check("result_async_reset", rd, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    load_and_start(32'd3, 32'd5, 32'd7);
    wait_done(2000, cyc, ok); check("done_3_5", ok, 1'b1);
    bus_rd(OFF_RESULT, rd); check("result_3_5", rd, 32'd5);

    // Unmapped offsets and deselected reads return 0
    bus_rd(3'd6, rd); check("read_off6", rd, 32'd0);
    bus_rd(3'd7, rd); check("read_off7", rd, 32'd0);
    sel = 1'b0; we = 1'b0; addr = OFF_BASE;
    #1;
    check("read_sel0", rdata, 32'd0);

    // Direct multiplier check: 12*15 mod 17 = 10, done W=16 cycles after start
    @(posedge clk); #1;
    mm_a = 16'd12; mm_b = 16'd15; mm_m = 16'd17; mm_start = 1'b1;
    @(posedge clk); #1;
    mm_start = 1'b0;
    cyc = 1;
    while (!mm_done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mm_latency", cyc, 32'd16);
    check("mm_product", mm_p, 32'd10);
    @(posedge clk); #1;
    check("mm_done_pulse", mm_done, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_mmio.md
Name: rsa_modexp_mmio

Overview:
- Memory-mapped modular-exponentiation coprocessor on the data-memory side of the pipelined ARM core.
- Consumes the core's data-bus outputs (address = ALUResult, WriteData, MemWrite) and returns ReadData when its address window is selected.
- Firmware loads base, exponent and modulus, writes start, then polls STATUS and reads RESULT.
- Offloads the RSA square-and-multiply loop from the CPU.

Parameters:
- W, 16, operand width in bits (2..32). Registers are zero-extended to 32 bits on read.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- sel  in  1  address window hit (decoded upstream from ALUResult)
- we  in  1  MemWrite from core; write occurs when sel & we at rising clk
- addr  in  3  word offset, ALUResult[4:2]
- wdata  in  32  WriteData from core
- rdata  out  32  read data, combinational from addr; 0 when sel=0
- irq  out  1  level, equals STATUS.done

Behaviour:
- Register map (word offset):
  - 0 BASE (rw)
  - 1 EXP (rw)
  - 2 MOD (rw)
  - 3 CTRL: write bit0=1 starts; reads 0
  - 4 STATUS (ro): bit0 busy, bit1 done, bit2 err
  - 5 RESULT (ro)
  - 6-7 read 0, writes ignored
- Operand writes latch wdata[W-1:0].
- Reset: all registers 0, FSM IDLE, busy=done=err=0, rdata=0, irq=0. Reset mid-operation aborts immediately; the result is discarded.
- While busy:
  - writes to BASE/EXP/MOD/CTRL are ignored
  - RESULT reads return the previous result
  - STATUS reads are live
- FSM:
  - IDLE: start → CHECK. Start clears done and err; busy=1 from the next cycle.
  - CHECK (1 cycle):
    - MOD==0 → err=1, RESULT=0 → DONE.
    - BASE>=MOD → err=1, RESULT=0 → DONE.
    - Otherwise load R=(MOD==1 ? 0 : 1), B=BASE, E=EXP → STEP.
  - STEP (1 cycle):
    - E==0 → RESULT=R → DONE.
    - E[0]=1 → launch R*B mod M → MUL.
    - Otherwise → SQR.
  - MUL: wait for mul_done, R←product → SQR.
  - SQR: launch B*B mod M, wait, B←product, E←E>>1 → STEP.
  - DONE (1 cycle): busy=0, done=1 (sticky until next start) → IDLE.
- Multiplier:
  - Interleaved shift-add, MSB-first, one bit per cycle, W cycles from launch to mul_done.
  - Per bit: acc←2·acc; if a[i], acc←acc+b; two conditional subtractions of M.
  - Internal width W+2 bits; invariant acc<M after each cycle.
- Exponent handling:
  - Leading zero bits of EXP cost nothing: the loop stops when E==0.
  - Worst case ≈ W·(2W+4)+3 cycles.
- EXP==0 gives RESULT=1 (0 when MOD==1).
- Start written in the same cycle as operand writes is impossible (single-port bus); the start uses the registers as they stand at that clock edge.

Decomposition:
- Package rsa_mmio_pkg:
  - register offset constants (OFF_BASE..OFF_RESULT)
  - STATUS bit indices
  - FSM state enum (IDLE, CHECK, STEP, MUL, SQR, DONE)
- Sub-module mod_mul:
  - ports: clk, reset, start, a, b, m (W bits each); out: done pulse, p (W bits)
  - requires a,b<m; busy internally for W cycles
- Top holds the register file, decode, FSM and read mux.

Test Plan:
- BASE=4, EXP=13, MOD=497, start → busy=1 next cycle; eventually done=1, irq=1, RESULT=445, err=0.
- BASE=2, EXP=10, MOD=1000 → RESULT=24. EXP=0, MOD=13 → RESULT=1. MOD=1 → RESULT=0.
- MOD=0 → err=1, done=1, RESULT=0 within 3 cycles of start. BASE=20, MOD=13 → err=1.
- During a 4^13 run, write BASE=9 and CTRL=1 → both ignored; final RESULT=445; BASE reads 4.
- Assert reset mid-run → rdata on STATUS=0 immediately; a fresh 3^5 mod 7 run then gives RESULT=5.
- Read offsets 6/7, and any offset with sel=0 → rdata=0. Direct mod_mul unit check: 12·15 mod 17 = 10, done exactly W cycles after start.
